// File: rtl/pll_seq_pkg.sv
// Shared state encodings, default timing constants and sizing helpers for
// the PLL lock sequencer.
package pll_seq_pkg;

  // Default timing, in refclk cycles (50 MHz reference).
  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_SYNC_STAGES         = 2;

  // Sequencer states.
  typedef logic [2:0] seq_state_t;
  localparam logic [2:0] ST_RESET_PLL = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  // Width of the shared cycle counter: enough to hold the largest terminal
  // value (count-1) of any of the three timing parameters.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-stage single-bit synchronizer with asynchronous active-low clear.
// Used for pll_locked and any other asynchronous status input.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input one stage per clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer flops, cleared to 0 so lock is never assumed out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor. Pulses the PLL reset, waits for a synchronized
// lock to stay stable, then releases the system reset. Retries on lock
// timeout, latches a fault after the retry budget, and re-sequences on loss
// of lock or on request. Runs only on refclk.
//
// Every output is registered and decoded from the state being entered, so
// each output reflects the state entered on that clock edge. sys_rst_n is
// only 1 in RUN; pll_rst is only 1 in RESET_PLL/FAULT, so it is never high
// together with ready.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic                             refclk,
  input  logic                             rst_n,
  input  logic                             pll_locked,
  input  logic                             force_relock,
  output logic                             pll_rst,
  output logic                             sys_rst_n,
  output logic                             ready,
  output logic                             fault,
  output logic                             lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                   LOCK_STABLE_CYCLES);
  localparam int RC_W  = $clog2(MAX_RETRIES + 1);

  // Terminal counts; each one forces a state change so the counter never wraps.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_MAX       = RC_W'(MAX_RETRIES);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RC_W-1:0]  retry_count_q, retry_count_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             lock_lost_q, lock_lost_d;
  logic             locked_sync;

  // pll_locked is asynchronous to refclk; this is its only point of use.
  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_locked_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_sync)
  );

  // Next-state, cycle counter and retry bookkeeping.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_count_d = retry_count_q;
    lock_lost_d   = 1'b0;
    case (state_q)
      ST_RESET_PLL: begin
        // force_relock is meaningless here: the PLL is already being reset.
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (force_relock) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end else if (locked_sync) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_count_q == RC_MAX) begin
            state_d = ST_FAULT;
          end else begin
            state_d       = ST_RESET_PLL;
            retry_count_d = retry_count_q + RC_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (force_relock) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end else if (!locked_sync) begin
          // A dropout restarts the whole wait, including the lock timeout.
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        // Loss of lock takes precedence so it is always reported.
        if (!locked_sync) begin
          state_d     = ST_RESET_PLL;
          lock_lost_d = 1'b1;
        end else if (force_relock) begin
          state_d = ST_RESET_PLL;
        end
      end
      ST_FAULT: begin
        cnt_d = '0;
        if (force_relock) begin
          state_d       = ST_RESET_PLL;
          retry_count_d = '0;
        end
      end
      default: begin
        state_d = ST_RESET_PLL;
        cnt_d   = '0;
      end
    endcase
    // A successful release starts the next sequence with a fresh budget.
    if (state_d == ST_RUN) retry_count_d = '0;
  end

  // Output decode from the state being entered.
  always_comb begin
    pll_rst_d   = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  // State, counters and registered outputs; reset holds the system and PLL.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RESET_PLL;
      cnt_q         <= '0;
      retry_count_q <= '0;
      pll_rst_q     <= 1'b1;
      sys_rst_n_q   <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_count_q <= retry_count_d;
      pll_rst_q     <= pll_rst_d;
      sys_rst_n_q   <= sys_rst_n_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_count_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer. Output vector is
// {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_count[1:0]}; every
// change of that vector is matched against a queue of {cycle, vector}
// entries pushed by the stimulus with hand-computed cycle numbers.
module tb_pll_lock_sequencer;

  localparam int W = 23;  // 16-bit cycle stamp + 7-bit output vector

  localparam logic [6:0] OUT_RESET = 7'b1000000;  // pll_rst only
  localparam logic [6:0] OUT_IDLE  = 7'b0000000;  // WAIT_LOCK / STABLE
  localparam logic [6:0] OUT_RUN   = 7'b0110000;  // sys_rst_n + ready

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [1:0] retry_count;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;
  int           cyc;
  int           t;
  logic [6:0]   prev_outs;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .SYNC_STAGES         (2)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .fault        (fault),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count)
  );

  // Clock and edge counter.
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  function automatic logic [6:0] cur_outs();
    return {pll_rst, sys_rst_n, ready, fault, lock_lost, retry_count};
  endfunction

  // Driver helpers: all input changes land 1 time unit after an edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic push_exp(input int stamp, input logic [6:0] outs);
    exp_q.push_back({stamp[15:0], outs});
  endtask

  task automatic check_now(input string name, input logic [6:0] exp_v);
    logic [6:0] got;
    got = cur_outs();
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got outs=%b required outs=%b", name, got, exp_v);
    end
  endtask

  // Monitor: on every output change outside reset, pop and compare.
  initial begin
    logic [6:0]   cur;
    logic [W-1:0] got_w;
    logic [W-1:0] exp_w;
    prev_outs = OUT_RESET;
    forever begin
      @(negedge refclk);
      cur = cur_outs();
      if (!rst_n) begin
        prev_outs = cur;
      end else begin
        checks++;
        if ((pll_rst && ready) || (sys_rst_n !== ready)) begin
          errors++;
          $display("FAIL invariant at cycle %0d: outs=%b", cyc, cur);
        end
        if (cur !== prev_outs) begin
          got_w = {cyc[15:0], cur};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: got cycle %0d outs=%b, none required",
                     cyc, cur);
          end else begin
            exp_w = exp_q.pop_front();
            if (got_w !== exp_w) begin
              errors++;
              $display("FAIL output_change: got cycle %0d outs=%b required cycle %0d outs=%b",
                       cyc, cur, exp_w[W-1:7], exp_w[6:0]);
            end
          end
          prev_outs = cur;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    checks       = 0;
    errors       = 0;
    tick(3);
    check_now("reset_state", OUT_RESET);

    // Normal bring-up: 4-cycle PLL reset, lock 10 cycles after it falls,
    // release 11 edges after pll_locked rises.
    rst_n = 1'b1;
    t = cyc;
    push_exp(t + 4, OUT_IDLE);
    tick_to(t + 14);
    pll_locked = 1'b1;
    t = cyc;
    push_exp(t + 11, OUT_RUN);
    tick_to(t + 16);

    // Loss of lock in RUN, then no lock at all: three PLL reset attempts
    // with retry_count 0,1,2 and finally FAULT with pll_rst held.
    pll_locked = 1'b0;
    t = cyc;
    push_exp(t + 3,  7'b1000100);
    push_exp(t + 4,  7'b1000000);
    push_exp(t + 7,  7'b0000000);
    push_exp(t + 27, 7'b1000001);
    push_exp(t + 31, 7'b0000001);
    push_exp(t + 51, 7'b1000010);
    push_exp(t + 55, 7'b0000010);
    push_exp(t + 75, 7'b1001010);
    tick_to(t + 105);

    // Recovery from FAULT with force_relock, then a normal release.
    t = cyc;
    force_relock = 1'b1;
    push_exp(t + 1, OUT_RESET);
    push_exp(t + 5, OUT_IDLE);
    tick(1);
    force_relock = 1'b0;
    tick_to(t + 15);
    pll_locked = 1'b1;
    t = cyc;
    push_exp(t + 11, OUT_RUN);
    tick_to(t + 15);

    // force_relock from RUN (no lock_lost), then a 1-cycle lock dropout
    // seen by STABLE at count 5: release needs 8 fresh stable cycles.
    t = cyc;
    force_relock = 1'b1;
    push_exp(t + 1,  OUT_RESET);
    push_exp(t + 5,  OUT_IDLE);
    push_exp(t + 21, OUT_RUN);
    tick(1);
    force_relock = 1'b0;
    tick_to(t + 9);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick_to(t + 24);

    // Asynchronous reset in the middle of RUN.
    @(posedge refclk);
    #3;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_run", OUT_RESET);
    tick(2);
    rst_n = 1'b1;
    t = cyc;
    push_exp(t + 4, OUT_IDLE);

    // Asynchronous reset in the middle of STABLE (count 3), then restart.
    tick_to(t + 8);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_stable", OUT_RESET);
    tick(2);
    rst_n = 1'b1;
    t = cyc;
    push_exp(t + 4,  OUT_IDLE);
    push_exp(t + 13, OUT_RUN);
    tick_to(t + 16);

    // Drain: every pushed expectation must have been seen.
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
    while (exp_q.size() != 0) begin
      logic [W-1:0] left_w;
      left_w = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_change: got nothing, required cycle %0d outs=%b",
               left_w[W-1:7], left_w[6:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
